led_pattern_fsm: RTL and testbench
==================================

Name: led_pattern_fsm

Overview:
- Downstream consumer of the 25 MHz clock divider's clk_1k and clk_1s outputs.
- Brings both divided clocks into the clk_25M domain as single-cycle ticks.
- Debounces a pushbutton on the 1 kHz tick.
- Runs a 4-mode LED pattern state machine that steps once per second.

Parameters:
- N_LED, 8: LED count (led width); must be ≥ 2.
- DEB_MS, 20: debounce interval in 1 kHz ticks (ms); must be ≥ 1.

Ports:
- clk_25M  input  1  system clock, 25 MHz; the only clock edge used.
- reset  input  1  asynchronous, active-low reset.
- clk_1k  input  1  1 kHz square wave from the divider; treated as data, never as a clock.
- clk_1s  input  1  1 Hz square wave from the divider; treated as data, never as a clock.
- btn_n  input  1  raw pushbutton, active-low, asynchronous to clk_25M.
- led  output  N_LED  LED drive pattern, registered.
- mode  output  2  current mode, registered.

Behaviour:
- Reset (reset=0, async):
  - mode=0; led={N_LED-1 zeros,1}.
  - clk_1k/clk_1s sync flops and history flops = 1, because the divider also resets its outputs high, so no false edge occurs.
  - btn sync flops = 1; debounced state = released; debounce counter = 0.
- Tick generation:
  - Each of clk_1k and clk_1s passes through 2 sync flops plus 1 history flop.
  - tick = sync2 & ~hist, high for exactly one clk_25M cycle per input rising edge.
  - A pattern update is visible on led ≤4 clk_25M cycles after a clk_1s rising edge.
- Debounce (all updates only on tick_1k):
  - btn_n goes through a 2-flop sync.
  - While the sampled level equals the debounced state, cnt=0.
  - Otherwise cnt increments; when cnt reaches DEB_MS-1 and the level still differs, the debounced state flips and cnt=0.
  - Counter width is $clog2(DEB_MS+1); it never wraps.
  - A released→pressed flip produces one press pulse (1 clk_25M cycle). A pressed→released flip produces nothing.
  - Holding the button produces exactly one press.
- Mode FSM:
  - States: SHIFT_L=0, SHIFT_R=1, BLINK=2, FILL=3.
  - A press advances mode 0→1→2→3→0.
  - In the same cycle led loads the new mode's initial pattern:
    - SHIFT_L: 0..01
    - SHIFT_R: 10..0
    - BLINK: all ones
    - FILL: all zeros
- Step on tick_1s (only when no press in the same cycle):
  - SHIFT_L: rotate left (MSB wraps to bit0).
  - SHIFT_R: rotate right (bit0 wraps to MSB).
  - BLINK: led = ~led.
  - FILL: if led is all ones, next is all zeros; else led = {led[N_LED-2:0],1}.
- Simultaneous press and tick_1s: the press wins, the initial pattern loads, and that tick is dropped.
- Reset asserted mid-operation: all state returns to reset values immediately; after release, the first step occurs on the next genuine clk_1s rising edge.
- mode output equals the FSM state register directly.

Optional Feature:
- Macro: LED_ACTIVE_LOW_EN.
- Defined: led port = bitwise inverse of the internal pattern, for boards with active-low LEDs. Reset value of led is {N_LED-1 ones,0}. FSM, mode and debounce behaviour are unchanged.
- Undefined: led port = internal pattern (active-high).

Test Plan:
Bench drives clk_1k/clk_1s directly as slow square waves; DEB_MS=3, N_LED=8.
1. Reset released, 3 clk_1s rising edges, no press → led 0x01→0x02→0x04→0x08, mode=0.
2. After 0x80 in SHIFT_L, one more clk_1s edge → led=0x01 (wrap).
3. btn_n low for 5 tick_1k then held low for 50 ticks → exactly one press pulse. mode=1, led=0x80; next clk_1s edge gives 0x40.
4. btn_n bounce (low 1 tick, high 1 tick, repeated 10×) → no press; mode and led unchanged.
5. mode=3 (FILL), 9 clk_1s edges → led 0x01,0x03,...,0xFF,0x00. Press coincident with a tick_1s edge in mode 3 → mode=0, led=0x01, that step dropped.
6. reset pulsed low mid-BLINK (led=0x00) → led=0x01, mode=0 asynchronously. Then:
   - With LED_ACTIVE_LOW_EN defined, rerun scenario 1 → led 0xFE→0xFD→0xFB→0xF7.

Source files
------------

// File: rtl/led_pattern_fsm.sv
// LED pattern sequencer: syncs the divider's 1 kHz / 1 Hz outputs into single-cycle ticks,
// debounces btn_n, and steps a 4-mode pattern FSM. Define LED_ACTIVE_LOW_EN for active-low LEDs.
module led_pattern_fsm #(
  parameter int N_LED  = 8,
  parameter int DEB_MS = 20
) (
  input  logic             clk_25M,
  input  logic             reset,
  input  logic             clk_1k,
  input  logic             clk_1s,
  input  logic             btn_n,
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode
);

  typedef enum logic [1:0] {
    SHIFT_L = 2'd0,
    SHIFT_R = 2'd1,
    BLINK   = 2'd2,
    FILL    = 2'd3
  } mode_e;

  localparam int CNT_W = $clog2(DEB_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_MS - 1);
  localparam logic [N_LED-1:0] PAT_ONE  = {{(N_LED-1){1'b0}}, 1'b1};

  // Bit 0 = sync1, bit 1 = sync2, bit 2 = history.
  logic [2:0] k_sync_q, s_sync_q;
  logic [1:0] btn_sync_q;
  logic       tick_1k, tick_1s;

  // Sync chains reset high to match the divider's reset level, so no false edge follows reset.
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      k_sync_q   <= 3'b111;
      s_sync_q   <= 3'b111;
      btn_sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
      k_sync_q   <= {k_sync_q[1:0], clk_1k};
      s_sync_q   <= {s_sync_q[1:0], clk_1s};
      btn_sync_q <= {btn_sync_q[0], btn_n};
    end
  end

  assign tick_1k = k_sync_q[1] & ~k_sync_q[2];
  assign tick_1s = s_sync_q[1] & ~s_sync_q[2];

  logic             deb_q, deb_d;   // 1 = pressed
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             level_pressed;

  assign level_pressed = ~btn_sync_q[1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (tick_1k) begin
      if (level_pressed == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d   = ~deb_q;
        cnt_d   = '0;
        press_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  function automatic logic [N_LED-1:0] init_pattern(input mode_e m);
    case (m)
      SHIFT_L: return PAT_ONE;
      SHIFT_R: return {1'b1, {(N_LED-1){1'b0}}};
      BLINK:   return '1;
      default: return '0;
    endcase
  endfunction

  mode_e            state_q;
  logic [N_LED-1:0] pattern_q;

  // A press outranks a coincident 1 s tick; that step is dropped.
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      state_q   <= SHIFT_L;
      pattern_q <= PAT_ONE;
    end else if (press_q) begin
      state_q   <= mode_e'(state_q + 2'd1);
      pattern_q <= init_pattern(mode_e'(state_q + 2'd1));
    end else if (tick_1s) begin
      case (state_q)
        SHIFT_L: pattern_q <= {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
        SHIFT_R: pattern_q <= {pattern_q[0], pattern_q[N_LED-1:1]};
        BLINK:   pattern_q <= ~pattern_q;
        default: pattern_q <= (&pattern_q) ? '0 : {pattern_q[N_LED-2:0], 1'b1};
      endcase
    end
  end

  assign mode = state_q;

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~pattern_q;
`else
  assign led = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_fsm.sv
// Bench for led_pattern_fsm: directed scenarios then random slots, checked against
// a slot-level model of modes, patterns and button debounce.
module tb_led_pattern_fsm;

  localparam int N_LED  = 8;
  localparam int DEB_MS = 3;

  logic             clk_25M = 1'b0;
  logic             reset   = 1'b0;
  logic             clk_1k  = 1'b0;
  logic             clk_1s  = 1'b0;
  logic             btn_n   = 1'b1;
  logic [N_LED-1:0] led;
  logic [1:0]       mode;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         m_mode = 0;
  logic [7:0] m_pat  = 8'h01;
  bit         m_deb  = 1'b0;
  int         m_run  = 0;

  led_pattern_fsm #(.N_LED(N_LED), .DEB_MS(DEB_MS)) dut (
    .clk_25M (clk_25M),
    .reset   (reset),
    .clk_1k  (clk_1k),
    .clk_1s  (clk_1s),
    .btn_n   (btn_n),
    .led     (led),
    .mode    (mode)
  );

  always #20 clk_25M = ~clk_25M;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_led(input logic [7:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  function automatic logic [7:0] init_pat(input int md);
    case (md)
      0:       return 8'h01;
      1:       return 8'h80;
      2:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] step_pat(input int md, input logic [7:0] p);
    int v;
    v = int'(p);
    case (md)
      0:       v = ((v * 2) + (v / 128)) % 256;
      1:       v = (v / 2) + ((v % 2) * 128);
      2:       v = 255 - v;
      default: v = (v == 255) ? 0 : ((v * 2) + 1) % 256;
    endcase
    return v[7:0];
  endfunction

  // One slot: set the button, optionally raise clk_1k, one cycle later optionally clk_1s, then check.
  task automatic slot(input bit k, input bit s, input bit b_n);
    bit press;
    press = 1'b0;
    @(negedge clk_25M);
    btn_n = b_n;
    repeat (4) @(negedge clk_25M);
    if (k) clk_1k = 1'b1;
    @(negedge clk_25M);
    if (s) clk_1s = 1'b1;
    repeat (8) @(negedge clk_25M);
    if (k) begin
      if (bit'(!b_n) != m_deb) begin
        m_run++;
        if (m_run == DEB_MS) begin
          m_deb = !m_deb;
          m_run = 0;
          press = m_deb;
        end
      end else begin
        m_run = 0;
      end
    end
    if (press) begin
      m_mode = (m_mode + 1) % 4;
      m_pat  = init_pat(m_mode);
    end else if (s) begin
      m_pat = step_pat(m_mode, m_pat);
    end
    check("led", led, exp_led(m_pat));
    check("mode", {6'b0, mode}, 8'(m_mode));
    clk_1k = 1'b0;
    clk_1s = 1'b0;
    repeat (4) @(negedge clk_25M);
  endtask

  task automatic press_release();
    repeat (DEB_MS) slot(1'b1, 1'b0, 1'b0);
    repeat (DEB_MS) slot(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    bit b;

    // Reset state
    repeat (3) @(negedge clk_25M);
    check("rst_led", led, exp_led(8'h01));
    check("rst_mode", {6'b0, mode}, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk_25M);
    check("no_false_edge", led, exp_led(8'h01));

    // Scenario 1/2: shift left and wrap
    repeat (3) slot(1'b0, 1'b1, 1'b1);
    check("s1_led", led, exp_led(8'h08));
    repeat (4) slot(1'b0, 1'b1, 1'b1);
    check("s2_msb", led, exp_led(8'h80));
    slot(1'b0, 1'b1, 1'b1);
    check("s2_wrap", led, exp_led(8'h01));

    // Scenario 3: long hold gives one press
    repeat (5) slot(1'b1, 1'b0, 1'b0);
    repeat (50) slot(1'b1, 1'b0, 1'b0);
    check("s3_mode", {6'b0, mode}, 8'h01);
    check("s3_led", led, exp_led(8'h80));
    repeat (DEB_MS) slot(1'b1, 1'b0, 1'b1);
    slot(1'b0, 1'b1, 1'b1);
    check("s3_step", led, exp_led(8'h40));

    // Scenario 4: bounce produces no press
    repeat (10) begin
      slot(1'b1, 1'b0, 1'b0);
      slot(1'b1, 1'b0, 1'b1);
    end
    check("s4_mode", {6'b0, mode}, 8'h01);
    check("s4_led", led, exp_led(8'h40));

    // Scenario 5: FILL sequence, then press coincident with a 1 s tick
    press_release();
    press_release();
    check("s5_mode", {6'b0, mode}, 8'h03);
    repeat (9) slot(1'b0, 1'b1, 1'b1);
    check("s5_fill_end", led, exp_led(8'h00));
    repeat (DEB_MS - 1) slot(1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b1, 1'b0);
    check("s5_coinc_mode", {6'b0, mode}, 8'h00);
    check("s5_coinc_led", led, exp_led(8'h01));
    repeat (DEB_MS) slot(1'b1, 1'b0, 1'b1);

    // Scenario 6: asynchronous reset mid-BLINK
    press_release();
    press_release();
    slot(1'b0, 1'b1, 1'b1);
    check("s6_blink", led, exp_led(8'h00));
    @(negedge clk_25M);
    #5 reset = 1'b0;
    #1;
    m_mode = 0; m_pat = 8'h01; m_deb = 1'b0; m_run = 0;
    check("s6_async_led", led, exp_led(8'h01));
    check("s6_async_mode", {6'b0, mode}, 8'h00);
    @(negedge clk_25M);
    reset = 1'b1;
    repeat (4) @(negedge clk_25M);
    check("s6_no_step", led, exp_led(8'h01));
    repeat (3) slot(1'b0, 1'b1, 1'b1);
    check("s6_rerun", led, exp_led(8'h08));

    // Random slots
    b = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 5) == 0) b = ~b;
      slot(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0), b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
